// File: rtl/mem_bus_arb_pkg.sv
// Shared types and constants for the mem_bus_arb arbiter.
//   arb_state_t : arbiter FSM states
//   ERR_DATA    : read data returned on a downstream timeout
//   MAX_NCH     : largest supported requester channel count
package mem_bus_arb_pkg;
    localparam int          MAX_NCH  = 8;
    localparam logic [31:0] ERR_DATA = 32'hdeadbeef;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} arb_state_t;
endpackage

// File: rtl/mem_bus_arb_rr_pick.sv
// rr_pick: combinational rotate-priority picker.
//   req    : per-channel request vector
//   rr_ptr : channel with highest priority this round
//   grant  : first requesting channel at or above rr_ptr (wrapping at NCH)
//   found  : at least one channel is requesting
module rr_pick #(
    parameter int NCH = 3,
    parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  rr_ptr,
    output logic [IW-1:0]  grant,
    output logic           found
);
    int idx;

    // Scan from the farthest offset down to 0 so the nearest hit wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int j = NCH - 1; j >= 0; j--) begin
            idx = (int'(rr_ptr) + j) % NCH;
            if (req[idx]) begin
                grant = IW'(idx);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_bus_arb.sv
// mem_bus_arb: round-robin arbiter sharing one downstream read/write port
// between NCH requester channels. One transaction is in flight at a time.
//   clk, reset             : clock, synchronous active-high reset
//   ch_rd_req/ch_wr_req    : level requests, held until completion pulse
//   ch_w/ch_hw             : size qualifiers; ch_adr/ch_wdata packed 32b/chan
//   ch_rd_valid/ch_wr_finish : one-cycle completion pulses, ch_rdata with reads
//   ch_err                 : timeout flag (only with MEM_BUS_ARB_TIMEOUT_EN)
//   read_* / write_*       : downstream command and response signals
//   busy                   : arbiter is not idle
// Optional feature: define MEM_BUS_ARB_TIMEOUT_EN to add a wait-cycle limit
// of TMO_CYC cycles; without it the wait states wait indefinitely.
module mem_bus_arb
    import mem_bus_arb_pkg::*;
#(
    parameter int NCH     = 3,
    parameter int TMO_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    ch_rd_req,
    input  logic [NCH-1:0]    ch_wr_req,
    input  logic [NCH-1:0]    ch_w,
    input  logic [NCH-1:0]    ch_hw,
    input  logic [NCH*32-1:0] ch_adr,
    input  logic [NCH*32-1:0] ch_wdata,
    output logic [NCH-1:0]    ch_rd_valid,
    output logic [NCH-1:0]    ch_wr_finish,
    output logic [31:0]       ch_rdata,
`ifdef MEM_BUS_ARB_TIMEOUT_EN
    output logic [NCH-1:0]    ch_err,
`endif
    output logic              read_req,
    output logic              read_w,
    output logic              read_hw,
    output logic [31:0]       read_adr,
    input  logic              read_valid,
    input  logic [31:0]       read_data,
    output logic              write_req,
    output logic              write_w,
    output logic              write_hw,
    output logic [31:0]       write_adr,
    output logic [31:0]       write_data,
    input  logic              write_finish,
    output logic              busy
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    arb_state_t  state, state_nx;
    logic [IW-1:0] rr_ptr, pick_g, g_q;
    logic        pick_found;
    logic        sel_rd, sel_w, sel_hw;
    logic [31:0] sel_adr, sel_wdata;
    logic        is_wr_q, w_q, hw_q, err_q, rreq_q, wreq_q, tmo_hit;
    logic [31:0] adr_q, wdata_q;

    rr_pick #(.NCH(NCH), .IW(IW)) u_pick (
        .req    (ch_rd_req | ch_wr_req),
        .rr_ptr (rr_ptr),
        .grant  (pick_g),
        .found  (pick_found)
    );

    // Attributes of the channel the picker selected.
    always_comb begin
        sel_rd    = 1'b0;
        sel_w     = 1'b0;
        sel_hw    = 1'b0;
        sel_adr   = '0;
        sel_wdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(pick_g) == i) begin
                sel_rd    = ch_rd_req[i];
                sel_w     = ch_w[i];
                sel_hw    = ch_hw[i];
                sel_adr   = ch_adr[i*32 +: 32];
                sel_wdata = ch_wdata[i*32 +: 32];
            end
        end
    end

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    logic [15:0] wait_cnt;
    // Hit on the cycle the counter would reach TMO_CYC.
    assign tmo_hit = (wait_cnt == 16'(TMO_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset)
            wait_cnt <= '0;
        else if (state == IDLE)
            wait_cnt <= '0;
        else if (state == RD_WAIT || state == WR_WAIT)
            wait_cnt <= wait_cnt + 16'd1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Read wins when the granted channel asks for both.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_found) state_nx = sel_rd ? RD_WAIT : WR_WAIT;
            RD_WAIT: if (read_valid || tmo_hit) state_nx = RESP;
            WR_WAIT: if (write_finish || tmo_hit) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            g_q      <= '0;
            is_wr_q  <= 1'b0;
            w_q      <= 1'b0;
            hw_q     <= 1'b0;
            adr_q    <= '0;
            wdata_q  <= '0;
            rreq_q   <= 1'b0;
            wreq_q   <= 1'b0;
            err_q    <= 1'b0;
            ch_rdata <= '0;
        end else begin
            rreq_q <= 1'b0;
            wreq_q <= 1'b0;
            if (state == IDLE && pick_found) begin
                g_q     <= pick_g;
                is_wr_q <= !sel_rd;
                w_q     <= sel_w;
                hw_q    <= sel_hw;
                adr_q   <= sel_adr;
                wdata_q <= sel_wdata;
                rreq_q  <= sel_rd;
                wreq_q  <= !sel_rd;
                err_q   <= 1'b0;
                if (int'(pick_g) == NCH - 1) rr_ptr <= '0;
                else                         rr_ptr <= pick_g + 1'b1;
            end
            if (state == RD_WAIT) begin
                if (read_valid) begin
                    ch_rdata <= read_data;
                end else if (tmo_hit) begin
                    ch_rdata <= ERR_DATA;
                    err_q    <= 1'b1;
                end
            end
            if (state == WR_WAIT && !write_finish && tmo_hit)
                err_q <= 1'b1;
        end
    end

    always_comb begin
        ch_rd_valid  = '0;
        ch_wr_finish = '0;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
        ch_err       = '0;
`endif
        for (int i = 0; i < NCH; i++) begin
            if (state == RESP && int'(g_q) == i) begin
                ch_rd_valid[i]  = !is_wr_q;
                ch_wr_finish[i] = is_wr_q;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
                ch_err[i]       = err_q;
`endif
            end
        end
    end

    assign read_req   = rreq_q;
    assign read_w     = w_q;
    assign read_hw    = hw_q;
    assign read_adr   = adr_q;
    assign write_req  = wreq_q;
    assign write_w    = w_q;
    assign write_hw   = hw_q;
    assign write_adr  = adr_q;
    assign write_data = wdata_q;
    assign busy       = (state != IDLE);
endmodule

// File: tb/tb_mem_bus_arb.sv
module tb_mem_bus_arb;
    localparam int NCH = 3;

    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    // 3-channel instance
    logic [NCH-1:0]    ch_rd_req = '0, ch_wr_req = '0, ch_w = '0, ch_hw = '0;
    logic [NCH*32-1:0] ch_adr = '0, ch_wdata = '0;
    logic [NCH-1:0]    ch_rd_valid, ch_wr_finish, ch_err;
    logic [31:0]       ch_rdata, read_adr, write_adr, write_data;
    logic              read_req, read_w, read_hw, write_req, write_w, write_hw, busy;
    logic              read_valid = 1'b0, write_finish = 1'b0;
    logic [31:0]       read_data = '0;

    // 1-channel instance
    logic       rd1 = 1'b0, wr1 = 1'b0, rv1 = 1'b0, wf1 = 1'b0;
    logic [0:0] rdv1, wrf1, err1;
    logic [31:0] rdata1, radr1, wadr1, wdat1;
    logic       rreq1, rw1, rhw1, wreq1, ww1, whw1, busy1;

    mem_bus_arb #(.NCH(NCH), .TMO_CYC(255)) u0 (
        .clk(clk), .reset(reset), .ch_rd_req(ch_rd_req), .ch_wr_req(ch_wr_req),
        .ch_w(ch_w), .ch_hw(ch_hw), .ch_adr(ch_adr), .ch_wdata(ch_wdata),
        .ch_rd_valid(ch_rd_valid), .ch_wr_finish(ch_wr_finish), .ch_rdata(ch_rdata),
`ifdef MEM_BUS_ARB_TIMEOUT_EN
        .ch_err(ch_err),
`endif
        .read_req(read_req), .read_w(read_w), .read_hw(read_hw), .read_adr(read_adr),
        .read_valid(read_valid), .read_data(read_data), .write_req(write_req),
        .write_w(write_w), .write_hw(write_hw), .write_adr(write_adr),
        .write_data(write_data), .write_finish(write_finish), .busy(busy)
    );

    mem_bus_arb #(.NCH(1), .TMO_CYC(4)) u1 (
        .clk(clk), .reset(reset), .ch_rd_req(rd1), .ch_wr_req(wr1),
        .ch_w(1'b1), .ch_hw(1'b0), .ch_adr(32'h0000_0200), .ch_wdata(32'h5a5a_0001),
        .ch_rd_valid(rdv1), .ch_wr_finish(wrf1), .ch_rdata(rdata1),
`ifdef MEM_BUS_ARB_TIMEOUT_EN
        .ch_err(err1),
`endif
        .read_req(rreq1), .read_w(rw1), .read_hw(rhw1), .read_adr(radr1),
        .read_valid(rv1), .read_data(32'h1111_2222), .write_req(wreq1),
        .write_w(ww1), .write_hw(whw1), .write_adr(wadr1),
        .write_data(wdat1), .write_finish(wf1), .busy(busy1)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // First requesting channel at or after p, wrapping.
    function automatic int pick(input logic [NCH-1:0] r, input int p);
        for (int j = 0; j < NCH; j++)
            if (r[(p + j) % NCH]) return (p + j) % NCH;
        return -1;
    endfunction

    // Reference model: transaction-level view of the arbiter.
    // open = a transaction is granted and not yet finished; fin = this cycle
    // is its completion cycle.
    bit          open, waiting, m_wr, did_rst;
    int          m_ch, m_ptr, cd, c, last, npulse, k2;
    logic [31:0] m_adr, m_wd, m_rdata;
    logic        m_w, m_hw, e_rreq, e_wreq, e_rv, e_wf;
    logic [1:0]  r;

    initial begin
        open = 0; waiting = 0; m_ptr = 0; m_rdata = '0; cd = 0; did_rst = 0;
        for (int k = 0; k < 1500; k++) begin
            @(posedge clk); #1;
            e_rreq = 0; e_wreq = 0; e_rv = 0; e_wf = 0;
            // Effect of the edge just taken, from inputs held across it.
            if (reset) begin
                open = 0; waiting = 0; m_ptr = 0; m_rdata = '0;
            end else if (!open) begin
                c = pick(ch_rd_req | ch_wr_req, m_ptr);
                if (c >= 0) begin
                    m_ch = c; m_wr = !ch_rd_req[c];
                    m_adr = ch_adr[c*32 +: 32]; m_wd = ch_wdata[c*32 +: 32];
                    m_w = ch_w[c]; m_hw = ch_hw[c];
                    m_ptr = (c + 1) % NCH;
                    open = 1; waiting = 1;
                    e_rreq = !m_wr; e_wreq = m_wr;
                end
            end else if (waiting) begin
                if (m_wr ? write_finish : read_valid) begin
                    if (!m_wr) m_rdata = read_data;
                    waiting = 0; e_rv = !m_wr; e_wf = m_wr;
                end
            end else begin
                open = 0;   // completion cycle over, no arbitration on it
            end

            chk("busy", busy, open);
            chk("read_req", read_req, e_rreq);
            chk("write_req", write_req, e_wreq);
            chk("ch_rd_valid", ch_rd_valid, e_rv ? (32'd1 << m_ch) : 32'd0);
            chk("ch_wr_finish", ch_wr_finish, e_wf ? (32'd1 << m_ch) : 32'd0);
            chk("ch_rdata", ch_rdata, m_rdata);
`ifdef MEM_BUS_ARB_TIMEOUT_EN
            chk("ch_err", ch_err, 0);
`endif
            if (e_rreq) begin
                chk("read_adr", read_adr, m_adr);
                chk("read_w", read_w, m_w);
                chk("read_hw", read_hw, m_hw);
            end
            if (e_wreq) begin
                chk("write_adr", write_adr, m_adr);
                chk("write_data", write_data, m_wd);
                chk("write_w", write_w, m_w);
                chk("write_hw", write_hw, m_hw);
            end

            // Drive inputs for the next edge.
            reset = (k < 2);
            if (!did_rst && k > 600 && open && waiting && !m_wr && !e_rreq) begin
                reset = 1; did_rst = 1;   // abandon a read in flight
            end
            if (e_rv) ch_rd_req[m_ch] = 1'b0;
            if (e_wf) ch_wr_req[m_ch] = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                if (!ch_rd_req[i] && !ch_wr_req[i] && $urandom_range(3) == 0) begin
                    r = 2'($urandom_range(1, 3));
                    ch_rd_req[i] = r[0]; ch_wr_req[i] = r[1];
                    ch_w[i] = 1'($urandom); ch_hw[i] = 1'($urandom);
                    ch_adr[i*32 +: 32] = $urandom;
                    ch_wdata[i*32 +: 32] = $urandom;
                end
            end
            read_valid = 0; write_finish = 0; read_data = $urandom;
            if (e_rreq || e_wreq) cd = $urandom_range(1, 3);
            else if (open && waiting) begin
                cd--;
                if (cd == 0) begin
                    if (m_wr) write_finish = 1; else read_valid = 1;
                end
            end
            // Stray responses that must be ignored.
            if (!(open && waiting && !m_wr) && $urandom_range(4) == 0) read_valid = 1;
            if (!(open && waiting && m_wr) && $urandom_range(4) == 0) write_finish = 1;
        end
        chk("reset_mid_read_seen", did_rst, 1);

        // Single channel, write request held: finish one cycle after each
        // write_req, so pulses repeat every 4 cycles.
        reset = 0; read_valid = 0; write_finish = 0;
        ch_rd_req = '0; ch_wr_req = '0;
        wr1 = 1; last = -100; npulse = 0; cd = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            chk("nch1_done", wrf1, (k == last + 2));
            if (wreq1) begin
                if (npulse > 0) chk("nch1_space", k - last, 4);
                chk("nch1_wadr", wadr1, 32'h0000_0200);
                chk("nch1_wdata", wdat1, 32'h5a5a_0001);
                last = k; npulse++; cd = 2;
            end
            wf1 = (cd == 1);
            if (cd > 0) cd--;
        end
        chk("nch1_count", npulse, 10);
        wr1 = 0; wf1 = 0;

`ifdef MEM_BUS_ARB_TIMEOUT_EN
        // Read never answered: timeout after TMO_CYC=4 wait cycles.
        rd1 = 1; k2 = -1;
        for (int k = 0; k < 20 && k2 < 0; k++) begin
            @(posedge clk); #1;
            if (rreq1) last = k;
            if (rdv1 != 0) begin
                k2 = k; rd1 = 0;
                chk("tmo_err", err1, 1);
                chk("tmo_rdata", rdata1, 32'hdeadbeef);
                chk("tmo_latency", k - last, 4);
            end
        end
        if (k2 < 0) chk("tmo_pulse_seen", 0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
